// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Shares one 8-bit UART transmitter among NUM_REQ byte-stream
//            requesters. Packet-level round-robin arbitration, optional
//            source-ID header byte (8'hA0 | id), packet length truncation at
//            MAX_PKT_LEN payload bytes, and a per-byte-phase watchdog that
//            abandons a packet when the UART stalls.
// Ports    : clk, rst        - clock, asynchronous active-high reset
//            reqValid/reqData/reqLast/reqReady - per-requester byte streams
//            grant, curId     - one-hot owner and its index (0 when idle)
//            txStart, txData, txBusy - UART transmit port
//            busy             - arbiter not idle
//            pktDone, pktTrunc, txTimeout - completion / truncation /
//                               watchdog event pulses
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter bit ADD_HEADER     = 1'b1,
    parameter int MAX_PKT_LEN    = 16,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     reqValid,
    input  logic [8*NUM_REQ-1:0]   reqData,
    input  logic [NUM_REQ-1:0]     reqLast,
    output logic [NUM_REQ-1:0]     reqReady,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   txStart,
    output logic [7:0]             txData,
    input  logic                   txBusy,
    output logic                   busy,
    output logic [2:0]             curId,
    output logic                   pktDone,
    output logic                   pktTrunc,
    output logic                   txTimeout
);

    localparam int                WD_W     = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0]   WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]        PKT_MAX  = 8'(MAX_PKT_LEN);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_HDR       = 3'd1,
        S_FETCH     = 3'd2,
        S_START     = 3'd3,
        S_WAIT_BUSY = 3'd4,
        S_WAIT_IDLE = 3'd5,
        S_RELEASE   = 3'd6
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [2:0]           curId_q, curId_d;
    logic [2:0]           lastId_q, lastId_d;
    logic [7:0]           txData_q, txData_d;
    logic                 txStart_q, txStart_d;
    logic                 last_q, last_d;     // latched reqLast of the byte in flight
    logic                 hdr_q, hdr_d;       // byte in flight is the header
    logic [7:0]           cnt_q, cnt_d;       // payload bytes sent in this grant
    logic [WD_W-1:0]      wd_q, wd_d;         // watchdog for the current UART phase
    logic                 busy_q, busy_d;
    logic                 pktDone_q, pktDone_d;
    logic                 pktTrunc_q, pktTrunc_d;
    logic                 txTimeout_q, txTimeout_d;

    logic [2:0]           w_pickId;
    logic                 w_selValid;
    logic                 w_selLast;
    logic [7:0]           w_selData;

    // Round-robin pick: the valid requester at the smallest circular distance
    // past lastId wins.
    always_comb begin : p_arb
        int v_dist;
        int v_best;
        w_pickId = 3'd0;
        v_best   = NUM_REQ;
        for (int j = 0; j < NUM_REQ; j++) begin
            v_dist = (j + 2 * NUM_REQ - 1 - int'(lastId_q)) % NUM_REQ;
            if (reqValid[j] && (v_dist < v_best)) begin
                v_best   = v_dist;
                w_pickId = 3'(j);
            end
        end
    end

    // Stream of the current owner.
    always_comb begin
        w_selValid = 1'b0;
        w_selLast  = 1'b0;
        w_selData  = 8'h00;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (curId_q == 3'(j)) begin
                w_selValid = reqValid[j];
                w_selLast  = reqLast[j];
                w_selData  = reqData[8*j +: 8];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        curId_d     = curId_q;
        lastId_d    = lastId_q;
        txData_d    = txData_q;
        txStart_d   = 1'b0;
        last_d      = last_q;
        hdr_d       = hdr_q;
        cnt_d       = cnt_q;
        wd_d        = wd_q;
        pktDone_d   = 1'b0;
        pktTrunc_d  = 1'b0;
        txTimeout_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (|reqValid) begin
                    grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pickId;
                    curId_d = w_pickId;
                    cnt_d   = 8'd0;
                    hdr_d   = 1'b0;
                    state_d = ADD_HEADER ? S_HDR : S_FETCH;
                end
            end
            S_HDR: begin
                txData_d  = 8'hA0 | {5'd0, curId_q};
                txStart_d = 1'b1;
                hdr_d     = 1'b1;
                wd_d      = '0;
                state_d   = S_WAIT_BUSY;
            end
            S_FETCH: begin
                if (w_selValid) begin
                    txData_d  = w_selData;
                    last_d    = w_selLast;
                    hdr_d     = 1'b0;
                    cnt_d     = cnt_q + 8'd1;
                    // Registered so the pulse lands in the START cycle.
                    txStart_d = 1'b1;
                    state_d   = S_START;
                end
            end
            S_START: begin
                wd_d    = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (txBusy) begin
                    wd_d    = '0;
                    state_d = S_WAIT_IDLE;
                end else if (wd_q == WD_LIMIT) begin
                    txTimeout_d = 1'b1;
                    state_d     = S_RELEASE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            S_WAIT_IDLE: begin
                if (!txBusy) begin
                    if (hdr_q) begin
                        state_d = S_FETCH;
                    end else if (last_q) begin
                        pktDone_d = 1'b1;
                        state_d   = S_RELEASE;
                    end else if (cnt_q == PKT_MAX) begin
                        pktDone_d  = 1'b1;
                        pktTrunc_d = 1'b1;
                        state_d    = S_RELEASE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end else if (wd_q == WD_LIMIT) begin
                    txTimeout_d = 1'b1;
                    state_d     = S_RELEASE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            S_RELEASE: begin
                lastId_d = curId_q;
                grant_d  = '0;
                curId_d  = 3'd0;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            curId_q     <= 3'd0;
            lastId_q    <= 3'(NUM_REQ - 1);
            txData_q    <= 8'h00;
            txStart_q   <= 1'b0;
            last_q      <= 1'b0;
            hdr_q       <= 1'b0;
            cnt_q       <= 8'd0;
            wd_q        <= '0;
            busy_q      <= 1'b0;
            pktDone_q   <= 1'b0;
            pktTrunc_q  <= 1'b0;
            txTimeout_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            curId_q     <= curId_d;
            lastId_q    <= lastId_d;
            txData_q    <= txData_d;
            txStart_q   <= txStart_d;
            last_q      <= last_d;
            hdr_q       <= hdr_d;
            cnt_q       <= cnt_d;
            wd_q        <= wd_d;
            busy_q      <= busy_d;
            pktDone_q   <= pktDone_d;
            pktTrunc_q  <= pktTrunc_d;
            txTimeout_q <= txTimeout_d;
        end
    end

    // The only combinational output: the owner may hand over a byte in FETCH.
    assign reqReady  = (state_q == S_FETCH) ? grant_q : '0;
    assign grant     = grant_q;
    assign curId     = curId_q;
    assign txStart   = txStart_q;
    assign txData    = txData_q;
    assign busy      = busy_q;
    assign pktDone   = pktDone_q;
    assign pktTrunc  = pktTrunc_q;
    assign txTimeout = txTimeout_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Self-checking bench for uart_tx_arbiter (4 requesters, header
//            on, MAX_PKT_LEN=4, TIMEOUT_CYCLES=50) with a UART responder, a
//            requester FIFO driver and a packet-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int N       = 4;
    localparam int MAXLEN  = 4;
    localparam int TIMEOUT = 50;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  reqValid = '0;
    logic [8*N-1:0] reqData = '0;
    logic [N-1:0]  reqLast = '0;
    logic [N-1:0]  reqReady;
    logic [N-1:0]  grant;
    logic          txStart;
    logic [7:0]    txData;
    logic          txBusy = 1'b0;
    logic          busy;
    logic [2:0]    curId;
    logic          pktDone;
    logic          pktTrunc;
    logic          txTimeout;

    uart_tx_arbiter #(
        .NUM_REQ        (N),
        .ADD_HEADER     (1'b1),
        .MAX_PKT_LEN    (MAXLEN),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .reqValid  (reqValid),
        .reqData   (reqData),
        .reqLast   (reqLast),
        .reqReady  (reqReady),
        .grant     (grant),
        .txStart   (txStart),
        .txData    (txData),
        .txBusy    (txBusy),
        .busy      (busy),
        .curId     (curId),
        .pktDone   (pktDone),
        .pktTrunc  (pktTrunc),
        .txTimeout (txTimeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Requester FIFOs: {last, data}; written by main, popped by the driver.
    logic [8:0] mem  [N][64];
    logic [5:0] head [N];
    logic [5:0] tail [N];
    logic [5:0] mhead[N];
    logic [N-1:0] hold = '0;
    logic [N-1:0] fire;
    logic stuck = 1'b0;

    logic [7:0] line_q[$];
    logic [N-1:0] grant_log[$];
    logic [7:0] exp_line[$];
    logic [N-1:0] exp_grant[$];
    int exp_done, exp_trunc;
    int mlast;

    int cnt_done = 0, cnt_trunc = 0, cnt_to = 0, bad_trunc = 0, bad_onehot = 0;
    logic [N-1:0] prev_grant = '0;

    initial begin
        for (int i = 0; i < N; i++) begin
            head[i] = '0; tail[i] = '0; mhead[i] = '0;
        end
    end

    // Requester driver: handshake sampled mid-cycle, FIFO popped after the edge.
    always begin
        @(negedge clk);
        fire = reqValid & reqReady;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (fire[i] && !rst) head[i] = head[i] + 6'd1;
            reqValid[i]       = (head[i] != tail[i]) && !hold[i];
            reqData[8*i +: 8] = mem[i][head[i]][7:0];
            reqLast[i]        = mem[i][head[i]][8];
        end
    end

    // UART responder: records each started byte, then busy for 1..4 edges
    // (or until released when stuck).
    always begin : p_uart
        int n;
        @(negedge clk);
        if (txStart === 1'b1) begin
            line_q.push_back(txData);
            @(posedge clk);
            #2 txBusy = 1'b1;
            if (stuck) begin
                wait (!stuck);
                txBusy = 1'b0;
            end else begin
                n = $urandom_range(1, 4);
                repeat (n) @(posedge clk);
                #2 txBusy = 1'b0;
            end
        end
    end

    // Event monitor.
    always @(negedge clk) begin
        if (rst) begin
            prev_grant <= '0;
        end else begin
            if (pktDone)   cnt_done  <= cnt_done + 1;
            if (pktTrunc)  cnt_trunc <= cnt_trunc + 1;
            if (txTimeout) cnt_to    <= cnt_to + 1;
            if (pktTrunc && !pktDone) bad_trunc <= bad_trunc + 1;
            if ($countones(grant) > 1 || $countones(reqReady) > 1) bad_onehot <= bad_onehot + 1;
            if (grant != prev_grant && grant != '0) grant_log.push_back(grant);
            prev_grant <= grant;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int id, input logic [7:0] d, input logic last);
        mem[id][tail[id]] = {last, d};
        tail[id] = tail[id] + 6'd1;
    endtask

    function automatic bit all_empty();
        bit e = 1'b1;
        for (int i = 0; i < N; i++) if (head[i] != tail[i]) e = 1'b0;
        return e;
    endfunction

    // Reference model: packets served whole in round-robin order, each
    // grant = header + payload up to the last flag or MAXLEN bytes.
    task automatic run_model();
        int id, n;
        bit fin;
        logic [8:0] e;
        exp_line.delete(); exp_grant.delete();
        exp_done = 0; exp_trunc = 0;
        while (1) begin
            id = -1;
            for (int k = 1; k <= N; k++) begin
                int c = (mlast + k) % N;
                if (id < 0 && mhead[c] != tail[c]) id = c;
            end
            if (id < 0) break;
            exp_line.push_back(8'hA0 | 8'(id));
            exp_grant.push_back(N'(1) << id);
            n = 0; fin = 1'b0;
            while (!fin) begin
                e = mem[id][mhead[id]];
                mhead[id] = mhead[id] + 6'd1;
                exp_line.push_back(e[7:0]);
                n++;
                if (e[8]) fin = 1'b1;
                else if (n == MAXLEN) begin fin = 1'b1; exp_trunc++; end
            end
            exp_done++;
            mlast = id;
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int quiet = 0;
        bit ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(posedge clk); #1;
            if (all_empty() && !busy && !txBusy) quiet++; else quiet = 0;
            if (quiet >= 4) ok = 1'b1;
        end
        chk({tag, "_drain"}, 32'(ok), 32'd1);
    endtask

    task automatic check_stream(input string tag, input int lb, input int gb);
        chk({tag, "_len"}, 32'(line_q.size() - lb), 32'(exp_line.size()));
        for (int k = 0; k < exp_line.size(); k++)
            if (lb + k < line_q.size()) chk({tag, "_byte"}, 32'(line_q[lb+k]), 32'(exp_line[k]));
        chk({tag, "_ngrant"}, 32'(grant_log.size() - gb), 32'(exp_grant.size()));
        for (int k = 0; k < exp_grant.size(); k++)
            if (gb + k < grant_log.size()) chk({tag, "_grant"}, 32'(grant_log[gb+k]), 32'(exp_grant[k]));
    endtask

    task automatic wait_cond_busy(input string tag, input int budget);
        bit ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(posedge clk); #1;
            if (txBusy) ok = 1'b1;
        end
        chk({tag, "_busy_seen"}, 32'(ok), 32'd1);
    endtask

    initial begin : p_main
        int lb, gb, d0, t0, to0, bad, k;
        bit got;
        logic [5:0] h3;
        rst = 1'b1;
        mlast = N - 1;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        chk("rst_reqReady", 32'(reqReady), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_txStart", 32'(txStart), 32'd0);
        chk("rst_txData", 32'(txData), 32'h00);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_curId", 32'(curId), 32'd0);
        chk("rst_flags", {29'd0, pktDone, pktTrunc, txTimeout}, 32'd0);
        @(negedge clk) rst = 1'b0;

        // ---------------- single packet, requester 2 ----------------
        lb = line_q.size(); gb = grant_log.size(); d0 = cnt_done;
        push(2, 8'h11, 1'b0); push(2, 8'h22, 1'b1);
        run_model();
        exp_line = '{8'hA2, 8'h11, 8'h22};
        exp_grant = '{4'b0100};
        drain("single", 500);
        check_stream("single", lb, gb);
        chk("single_done", 32'(cnt_done - d0), 32'd1);
        chk("single_grant_idle", 32'(grant), 32'd0);

        // ---------------- round robin, all requesters ----------------
        lb = line_q.size(); gb = grant_log.size(); d0 = cnt_done;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) push(i, 8'(16 * i + r), 1'b1);
        run_model();
        drain("rr", 2000);
        check_stream("rr", lb, gb);
        chk("rr_done", 32'(cnt_done - d0), 32'(exp_done));
        bad = 0;
        for (int j = gb; j + 3 < grant_log.size(); j++)
            if ((grant_log[j] | grant_log[j+1] | grant_log[j+2] | grant_log[j+3]) != 4'hF) bad++;
        chk("rr_fair", 32'(bad), 32'd0);

        // ---------------- truncation, requester 1 sends 6 bytes ----------------
        lb = line_q.size(); gb = grant_log.size(); d0 = cnt_done; t0 = cnt_trunc;
        for (int b = 0; b < 6; b++) push(1, 8'(8'h10 + b), b == 5);
        run_model();
        exp_line = '{8'hA1, 8'h10, 8'h11, 8'h12, 8'h13, 8'hA1, 8'h14, 8'h15};
        exp_grant = '{4'b0010, 4'b0010};
        drain("trunc", 1000);
        check_stream("trunc", lb, gb);
        chk("trunc_done", 32'(cnt_done - d0), 32'd2);
        chk("trunc_trunc", 32'(cnt_trunc - t0), 32'd1);

        // ---------------- randomized traffic ----------------
        for (int r = 0; r < 3; r++) begin
            lb = line_q.size(); gb = grant_log.size(); d0 = cnt_done; t0 = cnt_trunc;
            for (int i = 0; i < N; i++) begin
                int np = $urandom_range(0, 3);
                for (int p = 0; p < np; p++) begin
                    int len = $urandom_range(1, 6);
                    for (int b = 0; b < len; b++) push(i, 8'($urandom), b == len - 1);
                end
            end
            run_model();
            drain("rand", 5000);
            check_stream("rand", lb, gb);
            chk("rand_done", 32'(cnt_done - d0), 32'(exp_done));
            chk("rand_trunc", 32'(cnt_trunc - t0), 32'(exp_trunc));
        end

        // ---------------- reset mid-packet ----------------
        push(2, 8'h41, 1'b0); push(2, 8'h42, 1'b0); push(2, 8'h43, 1'b1);
        got = 1'b0;
        for (int n = 0; n < 300 && !got; n++) begin
            @(posedge clk); #1;
            if (head[2] == tail[2] - 6'd1) got = 1'b1;
        end
        chk("rstmid_reach", 32'(got), 32'd1);
        wait_cond_busy("rstmid", 100);
        @(posedge clk); #3 rst = 1'b1;
        #1;
        chk("rstmid_grant", 32'(grant), 32'd0);
        chk("rstmid_reqReady", 32'(reqReady), 32'd0);
        chk("rstmid_outs", {txData, curId, busy, txStart, pktDone, pktTrunc, txTimeout}, 32'd0);
        for (int i = 0; i < N; i++) begin
            tail[i] = head[i]; mhead[i] = head[i];
        end
        repeat (8) @(posedge clk);
        #3 rst = 1'b0;
        mlast = N - 1;
        lb = line_q.size(); gb = grant_log.size();
        push(3, 8'h93, 1'b1); push(0, 8'h90, 1'b1);
        run_model();
        drain("postrst", 500);
        check_stream("postrst", lb, gb);
        chk("postrst_first", 32'(line_q[lb]), 32'hA0);

        // ---------------- requester 0 stalls mid-packet ----------------
        lb = line_q.size(); gb = grant_log.size();
        push(0, 8'h31, 1'b0); push(3, 8'h77, 1'b1);
        got = 1'b0;
        for (int n = 0; n < 300 && !got; n++) begin
            @(posedge clk); #1;
            if (head[0] == tail[0]) got = 1'b1;
        end
        chk("stall_first_byte", 32'(got), 32'd1);
        hold[0] = 1'b1;
        push(0, 8'h32, 1'b1);
        h3 = head[3];
        bad = 0;
        repeat (100) begin
            @(posedge clk); #1;
            if (grant !== 4'b0001 || head[3] != h3) bad++;
        end
        chk("stall_grant_kept", 32'(bad), 32'd0);
        chk("stall_ready", 32'(reqReady), 32'h1);
        hold[0] = 1'b0;
        run_model();
        drain("stall", 500);
        check_stream("stall", lb, gb);

        // ---------------- watchdog on stuck txBusy ----------------
        lb = line_q.size(); d0 = cnt_done; to0 = cnt_to;
        stuck = 1'b1;
        push(0, 8'h5A, 1'b1); push(1, 8'hC3, 1'b1);
        wait_cond_busy("to", 100);
        // First poll that sees txBusy follows the edge that enters WAIT_IDLE.
        got = 1'b0; k = 0;
        while (k < 200 && !got) begin
            @(posedge clk); #1; k++;
            if (txTimeout) got = 1'b1;
        end
        chk("to_seen", 32'(got), 32'd1);
        chk("to_latency", 32'(k), 32'(TIMEOUT));
        chk("to_no_done", {30'd0, pktDone, pktTrunc}, 32'd0);
        chk("to_done_cnt", 32'(cnt_done - d0), 32'd0);
        stuck = 1'b0;
        @(posedge clk); #1;
        chk("to_grant_clear", 32'(grant), 32'd0);
        drain("to", 1000);
        exp_line = '{8'hA0, 8'hA1, 8'hC3, 8'hA0, 8'h5A};
        chk("to_len", 32'(line_q.size() - lb), 32'd5);
        for (int j = 0; j < 5; j++)
            if (lb + j < line_q.size()) chk("to_byte", 32'(line_q[lb+j]), 32'(exp_line[j]));
        chk("to_count", 32'(cnt_to - to0), 32'd1);
        chk("to_done_after", 32'(cnt_done - d0), 32'd2);

        chk("trunc_with_done", 32'(bad_trunc), 32'd0);
        chk("onehot", 32'(bad_onehot), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
